// File: rtl/jtframe_shadow_dump_pkg.sv
// Shared types for the shadow-RAM dump block: FSM encoding and stream size helper.
package jtframe_shadow_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_LO,
        ST_HI,
        ST_FIN
    } state_e;

    // Bytes streamed by one dump of a 2**lw word window
    function automatic int unsigned shadow_bytes(input int unsigned lw);
        return 32'd2 << lw;
    endfunction

endpackage

// File: rtl/jtframe_shadow_dump_if.sv
// Capture bus from the SDRAM bank-0 port plus the byte-stream handshake toward the dump sink.
interface jtframe_shadow_dump_if #(
    parameter int AW = 22
);
    logic [AW-1:0] ba0_addr;
    logic          wr0;
    logic [15:0]   din;
    logic [1:0]    din_m;
    logic [7:0]    st_data;
    logic          st_valid;
    logic          st_ready;
    logic          st_last;

    modport master (
        output ba0_addr, wr0, din, din_m, st_ready,
        input  st_data, st_valid, st_last
    );

    modport slave (
        input  ba0_addr, wr0, din, din_m, st_ready,
        output st_data, st_valid, st_last
    );
endinterface

// File: rtl/jtframe_dual_ram16.sv
// 16-bit simple dual-port RAM with per-byte write enables and a registered read port.
module jtframe_dual_ram16 #(
    parameter int aw = 10
)(
    input  logic          clk,
    input  logic [1:0]    we_i,
    input  logic [aw-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [aw-1:0] raddr_i,
    output logic [15:0]   q_o
);
    logic [15:0] mem [2**aw];

    always_ff @(posedge clk) begin
        if (we_i[0]) mem[waddr_i][7:0]  <= wdata_i[7:0];
        if (we_i[1]) mem[waddr_i][15:8] <= wdata_i[15:8];
        q_o <= mem[raddr_i];
    end
endmodule

// File: rtl/jtframe_shadow_dump.sv
// Shadows bank-0 writes inside a fixed window and streams a frozen snapshot out byte by byte.
module jtframe_shadow_dump
    import jtframe_shadow_dump_pkg::*;
#(
    parameter int            AW    = 22,
    parameter logic [AW-1:0] START = 22'h10_0000,
    parameter int            LW    = 15
)(
    input  logic                 clk_rom,
    input  logic                 rst_n,
    jtframe_shadow_dump_if.slave bus,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done
);
    localparam logic [LW-1:0] LAST = '1;

    state_e        state_q, state_d;
    logic [LW-1:0] addr_q, addr_d;
    logic [AW-1:0] off;
    logic          in_win;
    logic [1:0]    wmask;
    logic [15:0]   q;

    // Window test done as offset so START + 2**LW never has to be formed
    assign off    = bus.ba0_addr - START;
    assign in_win = (bus.ba0_addr >= START) && ((off >> LW) == '0);
    assign wmask  = (bus.wr0 && !busy && in_win) ? ~bus.din_m : 2'b00;

    jtframe_dual_ram16 #(.aw(LW)) u_ram (
        .clk     (clk_rom),
        .we_i    (wmask),
        .waddr_i (off[LW-1:0]),
        .wdata_i (bus.din),
        .raddr_i (addr_q),
        .q_o     (q)
    );

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_READ;
                addr_d  = '0;
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_LO;
            ST_LO:   if (bus.st_ready) state_d = ST_HI;
            ST_HI:   if (bus.st_ready) begin
                if (addr_q == LAST) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_READ;
                    addr_d  = addr_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Cancel wins over every transition, including a start seen in IDLE
        if (abort) begin
            state_d = ST_IDLE;
            addr_d  = '0;
        end
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_FIN);
        bus.st_valid = (state_q == ST_LO) || (state_q == ST_HI);
        bus.st_last  = (state_q == ST_HI) && (addr_q == LAST);
        bus.st_data  = 8'h00;
        if (state_q == ST_LO) bus.st_data = q[7:0];
        if (state_q == ST_HI) bus.st_data = q[15:8];
    end
endmodule
